// File: rtl/jtframe_dbgview_sched_pkg.sv
// Shared mode encodings and size limits for the debug-view scheduler.
package jtframe_dbg_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_AUTO   = 2'd1,
        MODE_FROZEN = 2'd2
    } mode_t;

    localparam int MAX_NSRC = 16;

endpackage

// File: rtl/jtframe_dbgview_find.sv
// Circular search for the nearest valid source above (i_dir=0) or below (i_dir=1) i_sel.
module jtframe_dbgview_find
    import jtframe_dbg_pkg::*;
#(
    parameter int NSRC = 4
) (
    input  logic [3:0]      i_sel,
    input  logic [NSRC-1:0] i_valid,
    input  logic            i_dir,
    output logic            o_found,
    output logic [3:0]      o_idx
);

    logic [MAX_NSRC-1:0] w_valid;
    logic [4:0]          w_cand;

    assign w_valid = MAX_NSRC'(i_valid);

    // Scan farthest-first so the nearest valid candidate is the last one written.
    always_comb begin
        o_found = 1'b0;
        o_idx   = i_sel;
        w_cand  = 5'd0;
        for (int k = NSRC - 1; k >= 1; k--) begin
            w_cand = i_dir ? (5'(i_sel) + 5'(NSRC - k)) : (5'(i_sel) + 5'(k));
            if (w_cand >= 5'(NSRC))
                w_cand = w_cand - 5'(NSRC);
            if (w_valid[w_cand[3:0]]) begin
                o_found = 1'b1;
                o_idx   = w_cand[3:0];
            end
        end
    end

endmodule

// File: rtl/jtframe_dbgview_sched.sv
// Selects one of NSRC probe bytes for the debug overlay, manual or auto-cycled,
// and latches it once per frame at the start of vblank.
module jtframe_dbgview_sched
    import jtframe_dbg_pkg::*;
#(
    parameter int NSRC         = 4,
    parameter int CYCLE_FRAMES = 60
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_lvbl,
    input  logic                i_view_next,
    input  logic                i_view_prev,
    input  logic                i_view_auto,
    input  logic                i_view_freeze,
    input  logic [8*NSRC-1:0]   i_src_data,
    input  logic [NSRC-1:0]     i_src_valid,
    output logic [7:0]          o_debug_view,
    output logic [3:0]          o_view_sel,
    output logic [1:0]          o_view_mode,
    output logic                o_frame_stb
);

    localparam logic [7:0] CNT_LAST = 8'(CYCLE_FRAMES - 1);

    logic        r_lvbl, r_next, r_prev, r_auto, r_freeze;
    logic [7:0]  r_cnt;
    logic [7:0]  r_debug_view;
    logic [3:0]  r_sel;
    logic        r_frame_stb;
    mode_t       r_mode, r_saved;

    logic [7:0]          w_src [MAX_NSRC];
    logic [MAX_NSRC-1:0] w_valid;
    logic                w_tick, w_next_e, w_prev_e, w_auto_e, w_freeze_e;
    logic                w_step_n, w_step_p;
    logic                w_found_n, w_found_p;
    logic [3:0]          w_idx_n, w_idx_p;

    // Unused slots read as zero so a 4-bit index never reaches past NSRC.
    for (genvar gi = 0; gi < MAX_NSRC; gi++) begin : g_src
        if (gi < NSRC) begin : g_used
            assign w_src[gi] = i_src_data[8*gi +: 8];
        end else begin : g_pad
            assign w_src[gi] = 8'h00;
        end
    end
    assign w_valid = MAX_NSRC'(i_src_valid);

    assign w_tick     = ~i_lvbl & r_lvbl;
    assign w_next_e   = i_view_next & ~r_next;
    assign w_prev_e   = i_view_prev & ~r_prev;
    assign w_auto_e   = i_view_auto & ~r_auto;
    assign w_freeze_e = i_view_freeze & ~r_freeze;
    assign w_step_n   = w_next_e & ~w_prev_e;
    assign w_step_p   = w_prev_e & ~w_next_e;

    jtframe_dbgview_find #(.NSRC(NSRC)) u_find_next (
        .i_sel   (r_sel),
        .i_valid (i_src_valid),
        .i_dir   (1'b0),
        .o_found (w_found_n),
        .o_idx   (w_idx_n)
    );

    jtframe_dbgview_find #(.NSRC(NSRC)) u_find_prev (
        .i_sel   (r_sel),
        .i_valid (i_src_valid),
        .i_dir   (1'b1),
        .o_found (w_found_p),
        .o_idx   (w_idx_p)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lvbl       <= 1'b0;
            r_next       <= 1'b0;
            r_prev       <= 1'b0;
            r_auto       <= 1'b0;
            r_freeze     <= 1'b0;
            r_cnt        <= 8'd0;
            r_debug_view <= 8'd0;
            r_sel        <= 4'd0;
            r_frame_stb  <= 1'b0;
            r_mode       <= MODE_MANUAL;
            r_saved      <= MODE_MANUAL;
        end else begin
            r_lvbl      <= i_lvbl;
            r_next      <= i_view_next;
            r_prev      <= i_view_prev;
            r_auto      <= i_view_auto;
            r_freeze    <= i_view_freeze;
            r_frame_stb <= w_tick;

            // Latch uses the selection held before this edge.
            if (w_tick && r_mode != MODE_FROZEN)
                r_debug_view <= w_valid[r_sel] ? w_src[r_sel] : 8'h00;

            case (r_mode)
                MODE_MANUAL: begin
                    if (w_freeze_e) begin
                        r_saved <= MODE_MANUAL;
                        r_mode  <= MODE_FROZEN;
                    end else begin
                        if (w_auto_e) begin
                            r_mode <= MODE_AUTO;
                            r_cnt  <= 8'd0;
                        end
                        if (w_step_n && w_found_n)
                            r_sel <= w_idx_n;
                        else if (w_step_p && w_found_p)
                            r_sel <= w_idx_p;
                    end
                end
                MODE_AUTO: begin
                    if (w_freeze_e) begin
                        r_saved <= MODE_AUTO;
                        r_mode  <= MODE_FROZEN;
                    end else begin
                        if (w_auto_e)
                            r_mode <= MODE_MANUAL;
                        // A manual step restarts the dwell period and pre-empts the timed step.
                        if (w_step_n || w_step_p) begin
                            r_cnt <= 8'd0;
                            if (w_step_n && w_found_n)
                                r_sel <= w_idx_n;
                            else if (w_step_p && w_found_p)
                                r_sel <= w_idx_p;
                        end else if (w_tick) begin
                            if (r_cnt == CNT_LAST) begin
                                r_cnt <= 8'd0;
                                if (w_found_n)
                                    r_sel <= w_idx_n;
                            end else begin
                                r_cnt <= r_cnt + 8'd1;
                            end
                        end
                    end
                end
                MODE_FROZEN: begin
                    if (w_freeze_e)
                        r_mode <= r_saved;
                end
                default: r_mode <= MODE_MANUAL;
            endcase
        end
    end

    assign o_debug_view = r_debug_view;
    assign o_view_sel   = r_sel;
    assign o_view_mode  = r_mode;
    assign o_frame_stb  = r_frame_stb;

endmodule

// File: tb/tb_jtframe_dbgview_sched.sv
// Randomized bench for jtframe_dbgview_sched against a transaction-level model.
module tb_jtframe_dbgview_sched;

    localparam int NSRC = 4;
    localparam int CF   = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                lvbl = 1'b1;
    logic                view_next = 1'b0, view_prev = 1'b0, view_auto = 1'b0, view_freeze = 1'b0;
    logic [8*NSRC-1:0]   src_data = '0;
    logic [NSRC-1:0]     src_valid = '0;
    logic [7:0]          debug_view;
    logic [3:0]          view_sel;
    logic [1:0]          view_mode;
    logic                frame_stb;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: 0=MANUAL 1=AUTO 2=FROZEN
    int         m_sel, m_mode, m_saved, m_cnt;
    logic [7:0] m_view;
    logic [7:0] m_data [NSRC];
    logic [NSRC-1:0] m_valid;

    jtframe_dbgview_sched #(.NSRC(NSRC), .CYCLE_FRAMES(CF)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_lvbl        (lvbl),
        .i_view_next   (view_next),
        .i_view_prev   (view_prev),
        .i_view_auto   (view_auto),
        .i_view_freeze (view_freeze),
        .i_src_data    (src_data),
        .i_src_valid   (src_valid),
        .o_debug_view  (debug_view),
        .o_view_sel    (view_sel),
        .o_view_mode   (view_mode),
        .o_frame_stb   (frame_stb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int search(input int sel, input bit up);
        for (int k = 1; k < NSRC; k++) begin
            int j;
            j = up ? (sel + k) % NSRC : (sel - k + NSRC) % NSRC;
            if (m_valid[j]) return j;
        end
        return sel;
    endfunction

    task automatic model_reset();
        m_sel = 0; m_mode = 0; m_saved = 0; m_cnt = 0; m_view = 8'h00;
    endtask

    task automatic drive_src();
        for (int i = 0; i < NSRC; i++) src_data[8*i +: 8] = m_data[i];
        src_valid = m_valid;
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".sel"},  32'(view_sel),   32'(m_sel));
        check({tag, ".mode"}, 32'(view_mode),  32'(m_mode));
        check({tag, ".view"}, 32'(debug_view), 32'(m_view));
    endtask

    task automatic keys(input bit n, input bit p, input bit a, input bit f);
        view_next = n; view_prev = p; view_auto = a; view_freeze = f;
        clk1();
        if (f) begin
            if (m_mode == 2) m_mode = m_saved;
            else begin m_saved = m_mode; m_mode = 2; end
        end else if (m_mode != 2) begin
            if (n ^ p) begin
                m_sel = search(m_sel, n);
                if (m_mode == 1) m_cnt = 0;
            end
            if (a) begin
                if (m_mode == 0) begin m_mode = 1; m_cnt = 0; end
                else m_mode = 0;
            end
        end
        $display("keys n=%0b p=%0b a=%0b f=%0b -> sel=%0d mode=%0d", n, p, a, f, view_sel, view_mode);
        check_state("keys");
        check("keys.stb", 32'(frame_stb), 32'd0);
        view_next = 0; view_prev = 0; view_auto = 0; view_freeze = 0;
        clk1();
    endtask

    task automatic frame();
        lvbl = 1'b0;
        clk1();
        if (m_mode != 2) m_view = m_valid[m_sel] ? m_data[m_sel] : 8'h00;
        if (m_mode == 1) begin
            if (m_cnt == CF - 1) begin m_sel = search(m_sel, 1'b1); m_cnt = 0; end
            else m_cnt++;
        end
        $display("frame -> view=%02h sel=%0d mode=%0d stb=%0b", debug_view, view_sel, view_mode, frame_stb);
        check("frame.stb1", 32'(frame_stb), 32'd1);
        check_state("frame");
        lvbl = 1'b1;
        clk1();
        check("frame.stb0", 32'(frame_stb), 32'd0);
    endtask

    task automatic rand_data();
        for (int i = 0; i < NSRC; i++) m_data[i] = 8'($urandom);
        drive_src();
    endtask

    initial begin
        logic [7:0] held_view;
        int         held_sel;
        int         exp_sel [7] = '{0, 0, 1, 1, 1, 2, 2};

        // Reset
        model_reset();
        m_data[0] = 8'h11; m_data[1] = 8'h22; m_data[2] = 8'h33; m_data[3] = 8'h44;
        m_valid = 4'hF;
        drive_src();
        clk1(); clk1();
        check("rst.view", 32'(debug_view), 32'h0);
        check("rst.sel",  32'(view_sel),   32'h0);
        check("rst.mode", 32'(view_mode),  32'h0);
        check("rst.stb",  32'(frame_stb),  32'h0);
        rst = 1'b0;
        clk1();

        // Test 1: first latch
        frame();
        check("t1.view", 32'(debug_view), 32'h11);

        // Test 2: skip invalid sources with wrap
        m_valid = 4'b1001; drive_src();
        keys(1, 0, 0, 0); check("t2.next", 32'(view_sel), 32'd3);
        keys(1, 0, 0, 0); check("t2.wrap", 32'(view_sel), 32'd0);
        keys(0, 1, 0, 0); check("t2.prev", 32'(view_sel), 32'd3);

        // Test 3: auto cycling
        m_valid = 4'hF; drive_src();
        keys(1, 0, 0, 0);
        keys(0, 0, 1, 0);
        check("t3.mode", 32'(view_mode), 32'd1);
        for (int t = 0; t < 7; t++) begin
            rand_data();
            frame();
            check("t3.sel", 32'(view_sel), 32'(exp_sel[t]));
        end

        // Test 4: freeze holds everything
        keys(0, 0, 0, 1);
        held_view = m_view; held_sel = m_sel;
        for (int t = 0; t < 10; t++) begin
            rand_data();
            frame();
        end
        check("t4.view", 32'(debug_view), 32'(held_view));
        check("t4.sel",  32'(view_sel),   32'(held_sel));
        keys(0, 0, 0, 1);
        check("t4.mode", 32'(view_mode), 32'd1);
        for (int t = 0; t < 4; t++) begin rand_data(); frame(); end

        // Test 5: simultaneous next/prev, then invalid selected source
        keys(1, 1, 0, 0);
        m_valid[m_sel] = 1'b0; drive_src();
        frame();
        check("t5.zero", 32'(debug_view), 32'h0);
        m_valid = 4'hF; drive_src();

        // Test 6: async reset while frozen at sel=2
        keys(0, 0, 1, 0);
        for (int t = 0; t < NSRC && m_sel != 2; t++) keys(1, 0, 0, 0);
        keys(0, 0, 0, 1);
        frame();
        check("t6.pre", 32'(view_sel), 32'd2);
        #3 rst = 1'b1;
        #1;
        check("t6.view", 32'(debug_view), 32'h0);
        check("t6.sel",  32'(view_sel),   32'h0);
        check("t6.mode", 32'(view_mode),  32'h0);
        check("t6.stb",  32'(frame_stb),  32'h0);
        model_reset();
        clk1();
        rst = 1'b0;
        clk1();
        rand_data();
        frame();

        // Random phase
        for (int it = 0; it < 300; it++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) m_valid = 4'($urandom);
            rand_data();
            case (op)
                0, 1:    keys(1, 0, 0, 0);
                2:       keys(0, 1, 0, 0);
                3:       keys(1, 1, 0, 0);
                4:       keys(0, 0, 1, 0);
                5:       keys(0, 0, 0, 1);
                6:       keys($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1);
                default: frame();
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
